// File: rtl/m_store_buffer.sv
// m_store_buffer: posted-write store buffer between the store byte-enable unit and the data-memory bus.
// Ports: st_* store request in (valid/ready), mem_* head entry out (valid/ready), ld_* load conflict probe, empty status.
// Latency: a store pushed at edge N is presented on mem_* after edge N. Backpressure: st_ready drops when all DEPTH entries are pending.
module m_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_byteen,
  input  logic [31:0] st_wdata,
  output logic        st_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        empty
);

  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_TWO  = (PTR_W+1)'(2);

  logic [29:0]      r_addr [DEPTH];
  logic [3:0]       r_be   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_merge;
  logic             w_alloc;
  logic [PTR_W-1:0] w_tail_m1;
  logic             w_conflict;
  logic             w_unused;

  // Byte offsets are irrelevant: everything is tracked per 32-bit word.
  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready  = (r_count != LP_FULL);
  assign mem_valid = (r_count != '0);
  assign empty     = (r_count == '0);

  assign w_push    = st_valid & st_ready & (st_byteen != 4'b0000);
  assign w_pop     = mem_valid & mem_ready;
  assign w_tail_m1 = r_tail - PTR_W'(1);

  // Only the youngest entry is a merge candidate, and only when it is not the
  // head (count>=2): the head may be mid-transfer on the bus.
  assign w_merge = w_push & (r_count >= LP_TWO) & (st_addr[31:2] == r_addr[w_tail_m1]);
  assign w_alloc = w_push & ~w_merge;

  // mem_* come straight from the head registers, so they stay stable under backpressure.
  assign mem_addr   = {r_addr[r_head], 2'b00};
  assign mem_byteen = r_be[r_head];
  assign mem_wdata  = r_data[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_be[i]   <= '0;
        r_data[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_merge) begin
        for (int b = 0; b < 4; b++) begin
          if (st_byteen[b]) r_data[w_tail_m1][8*b +: 8] <= st_wdata[8*b +: 8];
        end
        r_be[w_tail_m1] <= r_be[w_tail_m1] | st_byteen;
      end else if (w_alloc) begin
        r_addr[r_tail] <= st_addr[31:2];
        r_be[r_tail]   <= st_byteen;
        r_data[r_tail] <= st_wdata;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan the count entries starting at head; the head stays valid this cycle
  // even if it is being popped, and the incoming store is not considered.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_conflict = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (((PTR_W+1)'(i) < r_count) && (r_addr[w_idx] == ld_addr[31:2])) w_conflict = 1'b1;
    end
  end

  assign ld_conflict = ld_valid & w_conflict;

endmodule

// File: tb/tb_m_store_buffer.sv
module tb_m_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [3:0]  st_byteen = '0;
  logic [31:0] st_wdata = '0;
  logic        st_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_conflict;
  logic        empty;

  m_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen), .st_wdata(st_wdata),
    .st_ready(st_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view of the outputs from the pending-store list and current inputs.
  task automatic compare_outputs();
    logic hit;
    hit = 1'b0;
    foreach (q[i]) if (q[i].a == ld_addr[31:2]) hit = 1'b1;
    chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
    chk("ld_conflict", 32'(ld_conflict), 32'(ld_valid & hit));
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, {q[0].a, 2'b00});
      chk("mem_byteen", 32'(mem_byteen), 32'(q[0].be));
      chk("mem_wdata", mem_wdata, q[0].d);
    end
  endtask

  // Apply the rules of one clock edge to the pending-store list.
  task automatic model_edge();
    bit push, pop, merge;
    ent_t e;
    push  = st_valid && (q.size() != DEPTH) && (st_byteen != 4'b0000);
    pop   = (q.size() != 0) && mem_ready;
    merge = push && (q.size() >= 2) && (q[q.size()-1].a == st_addr[31:2]);
    if (merge) begin
      e = q[q.size()-1];
      for (int b = 0; b < 4; b++) if (st_byteen[b]) e.d[8*b +: 8] = st_wdata[8*b +: 8];
      e.be = e.be | st_byteen;
      q[q.size()-1] = e;
    end
    if (pop) void'(q.pop_front());
    if (push && !merge) begin
      e.a = st_addr[31:2]; e.be = st_byteen; e.d = st_wdata;
      q.push_back(e);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare, then advance the model at the rising edge.
  task automatic cyc(input logic sv, input logic [31:0] sa, input logic [3:0] sbe,
                     input logic [31:0] swd, input logic mr, input logic lv, input logic [31:0] la);
    @(negedge clk);
    st_valid = sv; st_addr = sa; st_byteen = sbe; st_wdata = swd;
    mem_ready = mr; ld_valid = lv; ld_addr = la;
    #1;
    compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic mr);
    cyc(1'b0, 32'h0, 4'h0, 32'h0, mr, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    st_valid = 1'b0; mem_ready = 1'b0; ld_valid = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    q.delete();
    #1;
  endtask

  initial begin
    // Reset state.
    do_reset();
    ld_valid = 1'b1; ld_addr = 32'h0;
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_byteen", 32'(mem_byteen), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);

    // Single store then drain.
    cyc(1'b1, 32'h0000_1004, 4'b0011, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0);
    chk("single_valid", 32'(mem_valid), 32'd1);
    chk("single_addr", mem_addr, 32'h0000_1004);
    chk("single_be", 32'(mem_byteen), 32'h3);
    chk("single_data", mem_wdata, 32'h0000_BEEF);
    idle(1'b1);
    chk("single_empty", 32'(empty), 32'd1);

    // Fill and backpressure.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 32'h0);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    cyc(1'b1, 32'h200, 4'hF, 32'hDEAD_0005, 1'b0, 1'b0, 32'h0);
    chk("full_5th_refused", 32'(q.size()), 32'd4);
    idle(1'b1);
    chk("after_pop_ready", 32'(st_ready), 32'd1);
    chk("after_pop_head", mem_addr, 32'h104);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("fill_drained", 32'(empty), 32'd1);

    // Coalesce into the tail entry.
    cyc(1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h20, 4'b0001, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h20, 4'b1000, 32'h2200_0000, 1'b0, 1'b0, 32'h0);
    chk("merge_count", 32'(q.size()), 32'd2);
    idle(1'b1);
    chk("merge_addr", mem_addr, 32'h20);
    chk("merge_be", 32'(mem_byteen), 32'h9);
    chk("merge_data", mem_wdata, 32'h2200_0011);
    idle(1'b1);
    chk("merge_empty", 32'(empty), 32'd1);

    // Head entry is never merged.
    cyc(1'b1, 32'h30, 4'b0001, 32'h0000_00AA, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h30, 4'b0010, 32'h0000_BB00, 1'b0, 1'b0, 32'h0);
    chk("nohead_count", 32'(q.size()), 32'd2);
    idle(1'b1);
    chk("nohead_second_valid", 32'(mem_valid), 32'd1);
    chk("nohead_second_be", 32'(mem_byteen), 32'h2);
    idle(1'b1);
    chk("nohead_empty", 32'(empty), 32'd1);

    // Load conflict.
    cyc(1'b1, 32'h40, 4'hF, 32'h4040_4040, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h44, 4'hF, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h46; #1;
    chk("ld_0x46", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h48; #1;
    chk("ld_0x48", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0; ld_addr = 32'h40; #1;
    chk("ld_invalid", 32'(ld_conflict), 32'd0);
    cyc(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h40);

    // Async reset mid-drain.
    cyc(1'b1, 32'h50, 4'hF, 32'h5050_5050, 1'b0, 1'b0, 32'h0);
    chk("pre_reset_count", 32'(q.size()), 32'd3);
    @(posedge clk); #2;
    mem_ready = 1'b0;
    reset = 1'b1; #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_st_ready", 32'(st_ready), 32'd1);
    #1; reset = 1'b0;
    q.delete();
    cyc(1'b1, 32'h0000_2008, 4'b1100, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0);
    chk("post_rst_valid", 32'(mem_valid), 32'd1);
    chk("post_rst_addr", mem_addr, 32'h0000_2008);
    chk("post_rst_data", mem_wdata, 32'hCAFE_0000);
    idle(1'b1);

    // Randomized traffic over a small word set so merges and conflicts are frequent.
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 99) < 60),
          32'h200 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)),
          $urandom,
          1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 1)),
          32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 8; n++) idle(1'b1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
